// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the programmable serial pattern-detect controller:
// one-hot state codes, length-field sizing and length clamping.
package seq_ctrl_pkg;

  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_ARMED = 4'b0010;
  localparam logic [3:0] ST_RUN   = 4'b0100;
  localparam logic [3:0] ST_DONE  = 4'b1000;

  function automatic int calc_len_w(input int pat_w);
    return $clog2(pat_w) + 1;
  endfunction

  // A zero or oversized length selects the full pattern width.
  function automatic int clamp_len(input int len, input int pat_w);
    if (len == 0 || len > pat_w) return pat_w;
    return len;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Shift-register matcher: keeps the recent bit history and a saturating fill
// count, and flags (combinationally) when the bit being shifted in completes the pattern.
module seq_match_core #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             din,
  input  logic [LEN_W-1:0] len,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             hit
);

  logic [PAT_W-1:0] history;
  logic [PAT_W-1:0] hist_next;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill;
  logic             fill_ok;

  assign hist_next = {history[PAT_W-2:0], din};
  // Shifting by len == PAT_W yields zero, so the mask becomes all ones.
  assign mask      = ~({PAT_W{1'b1}} << len);
  assign fill_ok   = ({1'b0, fill} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, len};
  assign hit       = shift_en && fill_ok && (((hist_next ^ pattern) & mask) == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      history <= '0;
      fill    <= '0;
    end else if (clr) begin
      history <= '0;
      fill    <= '0;
    end else if (shift_en) begin
      history <= hist_next;
      if (hit && !overlap)
        fill <= '0;
      else if (fill != LEN_W'(PAT_W))
        fill <= fill + LEN_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run-time programmable pattern-detect controller: latches a configuration,
// arms, scans qualified serial data through seq_match_core and counts matches.
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter  int PAT_W = 8,
  parameter  int CNT_W = 8,
  localparam int LEN_W = calc_len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             data_valid,
  input  logic             data,
  output logic             flag,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done
);

  logic [3:0]       state;
  logic [PAT_W-1:0] pattern_r;
  logic [LEN_W-1:0] len_r;
  logic             overlap_r;
  logic [CNT_W-1:0] target_r;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit;
  logic             core_clr;
  logic             core_shift;

  assign cfg_ready  = (state == ST_IDLE);
  assign busy       = (state == ST_RUN);
  assign core_clr   = (state == ST_ARMED) && start && !abort;
  assign core_shift = (state == ST_RUN) && data_valid;
  assign cnt_inc    = (&match_cnt) ? match_cnt : match_cnt + CNT_W'(1);

  seq_match_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .clr      (core_clr),
    .shift_en (core_shift),
    .din      (data),
    .len      (len_r),
    .pattern  (pattern_r),
    .overlap  (overlap_r),
    .hit      (hit)
  );

  // Abort wins over everything; match_cnt is left intact so it can be read after abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      pattern_r <= '0;
      len_r     <= '0;
      overlap_r <= 1'b0;
      target_r  <= '0;
      match_cnt <= '0;
      flag      <= 1'b0;
      done      <= 1'b0;
    end else begin
      flag <= 1'b0;
      done <= 1'b0;
      if (abort) begin
        state     <= ST_IDLE;
        pattern_r <= '0;
        len_r     <= '0;
        overlap_r <= 1'b0;
        target_r  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cfg_valid) begin
              pattern_r <= cfg_pattern;
              len_r     <= LEN_W'(clamp_len(int'(cfg_len), PAT_W));
              overlap_r <= cfg_overlap;
              target_r  <= cfg_target;
              state     <= ST_ARMED;
            end
          end
          ST_ARMED: begin
            if (start) begin
              match_cnt <= '0;
              state     <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (hit) begin
              flag      <= 1'b1;
              match_cnt <= cnt_inc;
              if (target_r != '0 && cnt_inc == target_r)
                state <= ST_DONE;
            end
          end
          ST_DONE: begin
            done  <= 1'b1;
            state <= ST_ARMED;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Randomised and directed bench for seq_detect_ctrl; a monitor checks every
// flag/done pulse against events predicted by a bit-list reference model.
module tb_seq_detect_ctrl;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int LEN_W = 4;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;
  localparam int M_DONE  = 3;

  localparam int EV_FLAG = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int kind;
    int cyc;
    int cnt;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic [CNT_W-1:0] cfg_target = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             data_valid = 1'b0;
  logic             data = 1'b0;
  logic             flag;
  logic [CNT_W-1:0] match_cnt;
  logic             busy;
  logic             done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  ev_t exp_q[$];

  int               m_state = M_IDLE;
  logic [PAT_W-1:0] m_pat = '0;
  int               m_len = 0;
  logic             m_ovl = 1'b0;
  int               m_tgt = 0;
  int               m_cnt = 0;
  logic             m_bits[$];

  seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .start       (start),
    .abort       (abort),
    .data_valid  (data_valid),
    .data        (data),
    .flag        (flag),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_check(input int kind, input string name);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("[TB] FAIL %s: unexpected pulse at cycle %0d, expected none", name, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || (kind == EV_FLAG && e.cnt != int'(match_cnt))) begin
        fails++;
        $display("[TB] FAIL %s: got kind %0d cycle %0d cnt %0d, expected kind %0d cycle %0d cnt %0d",
                 name, kind, cyc, match_cnt, e.kind, e.cyc, e.cnt);
      end
    end
  endtask

  // Monitor: every pulse the DUT presents must be the next predicted event.
  always @(negedge clk) begin
    if (rst) begin
      if (flag) pop_check(EV_FLAG, "flag");
      if (done) pop_check(EV_DONE, "done");
    end
  end

  function automatic bit model_match();
    int n = m_bits.size();
    if (n < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++)
      if (m_bits[n-1-i] != m_pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Drive one cycle of inputs, advance the reference model, then check state outputs.
  task automatic apply_stimulus(input logic cv, input logic s, input logic a,
                                input logic v, input logic d);
    cfg_valid  = cv;
    start      = s;
    abort      = a;
    data_valid = v;
    data       = d;
    if (a) begin
      m_state = M_IDLE;
    end else begin
      case (m_state)
        M_IDLE: if (cv) begin
          m_pat   = cfg_pattern;
          m_len   = (cfg_len == 0 || int'(cfg_len) > PAT_W) ? PAT_W : int'(cfg_len);
          m_ovl   = cfg_overlap;
          m_tgt   = int'(cfg_target);
          m_state = M_ARMED;
        end
        M_ARMED: if (s) begin
          m_cnt = 0;
          m_bits.delete();
          m_state = M_RUN;
        end
        M_RUN: if (v) begin
          m_bits.push_back(d);
          if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
          if (model_match()) begin
            if (m_cnt < 255) m_cnt++;
            exp_q.push_back('{EV_FLAG, cyc + 1, m_cnt});
            if (!m_ovl) m_bits.delete();
            if (m_tgt != 0 && m_cnt == m_tgt) m_state = M_DONE;
          end
        end
        default: begin
          exp_q.push_back('{EV_DONE, cyc + 1, 0});
          m_state = M_ARMED;
        end
      endcase
    end
    @(posedge clk);
    @(negedge clk);
    check_output("cfg_ready", int'(cfg_ready), int'(m_state == M_IDLE));
    check_output("busy", int'(busy), int'(m_state == M_RUN));
    check_output("match_cnt", int'(match_cnt), m_cnt);
  endtask

  task automatic configure(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                           input logic o, input logic [CNT_W-1:0] t);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cfg_target  = t;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, bits[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_start();
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_abort();
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_output("reset_cfg_ready", int'(cfg_ready), 1);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_flag", int'(flag), 0);
    check_output("reset_done", int'(done), 0);
    check_output("reset_match_cnt", int'(match_cnt), 0);
    rst = 1'b1;

    // Overlapping detection of 1011 in 1011011.
    configure(8'b1011, 4'd4, 1'b1, 8'd0);
    do_start();
    send_bits(16'b1011011, 7);
    idle(2);
    check_output("overlap_cnt", int'(match_cnt), 2);
    do_abort();

    // Same stream without overlap.
    configure(8'b1011, 4'd4, 1'b0, 8'd0);
    do_start();
    send_bits(16'b1011011, 7);
    idle(2);
    check_output("nonoverlap_cnt", int'(match_cnt), 1);
    do_abort();

    // Target of two with a data_valid gap mid-stream.
    configure(8'b10111, 4'd5, 1'b0, 8'd2);
    do_start();
    send_bits(16'b10111, 5);
    send_bits(16'b10, 2);
    idle(3);
    send_bits(16'b111, 3);
    idle(3);
    check_output("target_cnt", int'(match_cnt), 2);
    do_start();
    check_output("restart_cnt", int'(match_cnt), 0);
    do_abort();

    // Length clamp: 0 and PAT_W+3 both act as a full 8-bit pattern.
    configure(8'hA5, 4'd0, 1'b0, 8'd0);
    do_start();
    send_bits(16'h00A5, 8);
    idle(1);
    check_output("clamp0_cnt", int'(match_cnt), 1);
    do_abort();
    configure(8'hA5, 4'(PAT_W + 3), 1'b0, 8'd0);
    do_start();
    send_bits(16'h05A5, 12);
    idle(1);
    check_output("clamp11_cnt", int'(match_cnt), 1);
    do_abort();

    // Configuration offered while armed is ignored; abort beats a completing bit.
    configure(8'b1011, 4'd4, 1'b0, 8'd0);
    cfg_pattern = 8'h00;
    cfg_len     = 4'd2;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_start();
    send_bits(16'b1011, 4);
    check_output("armed_cfg_kept_cnt", int'(match_cnt), 1);
    send_bits(16'b101, 3);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_output("abort_cfg_ready", int'(cfg_ready), 1);
    check_output("abort_flag", int'(flag), 0);
    idle(1);

    // Randomised configurations, streams and occasional aborts.
    for (int n = 0; n < 1500; n++) begin
      case (m_state)
        M_IDLE: begin
          cfg_pattern = 8'($urandom);
          cfg_len     = 4'($urandom_range(0, 6));
          cfg_overlap = 1'($urandom);
          cfg_target  = 8'($urandom_range(0, 3));
          apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom), 1'b0, 1'b0, 1'b0);
        end
        M_ARMED:
          apply_stimulus(1'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0,
                         1'($urandom), 1'($urandom));
        default:
          apply_stimulus(1'($urandom), 1'($urandom), $urandom_range(0, 80) == 0,
                         $urandom_range(0, 3) != 0, 1'($urandom));
      endcase
    end
    do_abort();

    // Asynchronous reset between edges while a flag pulse is showing.
    configure(8'b11, 4'd2, 1'b1, 8'd0);
    do_start();
    send_bits(16'b11, 2);
    #2 rst = 1'b0;
    #1;
    check_output("async_flag", int'(flag), 0);
    check_output("async_busy", int'(busy), 0);
    check_output("async_cfg_ready", int'(cfg_ready), 1);
    check_output("async_match_cnt", int'(match_cnt), 0);
    check_output("async_done", int'(done), 0);
    exp_q.delete();
    m_state = M_IDLE;
    m_cnt   = 0;
    m_bits.delete();
    @(negedge clk);
    #1 rst = 1'b1;
    do_start();
    check_output("start_without_cfg_busy", int'(busy), 0);
    idle(3);

    check_output("pending_events", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
